// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock level FIFO.
// Holds the pointer/count width helper and the bit positions of the
// status vector that CSR readback exposes.
package sync_fifo_pkg;

  localparam int FLAG_FULL    = 0;
  localparam int FLAG_EMPTY   = 1;
  localparam int FLAG_AFULL   = 2;
  localparam int FLAG_AEMPTY  = 3;
  localparam int FLAG_OVF     = 4;
  localparam int FLAG_UDF     = 5;
  localparam int STATUS_W     = 6;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  function automatic int ptr_width(input int ptr_size);
    return ptr_size + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_1clk.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are never cleared; only the read register is reset.
// A same-address read and write in one cycle returns the old word.
module fifo_ram_1clk #(
  parameter int fifo_data_size = 8,
  parameter int fifo_ptr_size  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [fifo_ptr_size-1:0]  wr_addr,
  input  logic [fifo_data_size-1:0] wr_data,
  input  logic                      rd_en,
  input  logic [fifo_ptr_size-1:0]  rd_addr,
  output logic [fifo_data_size-1:0] rd_data
);

  localparam int DEPTH = 2 ** fifo_ptr_size;

  logic [fifo_data_size-1:0] mem [DEPTH];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, cleared on reset so the output starts at zero.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through
// output; otherwise rd_data is a registered read strobed by rd_data_valid.
module sync_fifo_level
  import sync_fifo_pkg::*;
#(
  parameter int fifo_data_size = 8,
  parameter int fifo_ptr_size  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  input  logic [fifo_data_size-1:0] wr_data,
  input  logic                      rd_valid,
  output logic [fifo_data_size-1:0] rd_data,
  output logic                      rd_data_valid,
  input  logic [fifo_ptr_size:0]    af_level,
  input  logic [fifo_ptr_size:0]    ae_level,
  output logic [fifo_ptr_size:0]    fifo_count,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_almost_full,
  output logic                      fifo_almost_empty,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int CW = ptr_width(fifo_ptr_size);
  localparam int AW = fifo_ptr_size;
  localparam logic [CW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [CW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                wr_acc, rd_acc, ovf_set, udf_set;
  logic [STATUS_W-1:0] status;

  logic                      ram_rd_en;
  logic [AW-1:0]             ram_rd_addr;
  logic [fifo_data_size-1:0] ram_q;

  // Accept decisions and next pointers; a write may enter a full FIFO
  // only when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc     = rd_valid && !status[FLAG_EMPTY];
    wr_acc     = wr_valid && (!status[FLAG_FULL] || rd_acc);
    ovf_set    = wr_valid && !wr_acc;
    udf_set    = rd_valid && status[FLAG_EMPTY];
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  end

  // Read and write pointers, modulo 2**(AW+1).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  assign fifo_count = wr_ptr - rd_ptr;

  // Status flags registered from the post-edge count; clr_err beats a
  // same-cycle error so software never misses its own clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      status              <= '0;
      status[FLAG_EMPTY]  <= 1'b1;
      status[FLAG_AEMPTY] <= 1'b1;
    end else begin
      status[FLAG_FULL]   <= (count_nxt == DEPTH);
      status[FLAG_EMPTY]  <= (count_nxt == '0);
      status[FLAG_AFULL]  <= (count_nxt >= af_level);
      status[FLAG_AEMPTY] <= (count_nxt <= ae_level);
      status[FLAG_OVF]    <= clr_err ? 1'b0 : (status[FLAG_OVF] | ovf_set);
      status[FLAG_UDF]    <= clr_err ? 1'b0 : (status[FLAG_UDF] | udf_set);
    end
  end

  assign fifo_full         = status[FLAG_FULL];
  assign fifo_empty        = status[FLAG_EMPTY];
  assign fifo_almost_full  = status[FLAG_AFULL];
  assign fifo_almost_empty = status[FLAG_AEMPTY];
  assign overflow          = status[FLAG_OVF];
  assign underflow         = status[FLAG_UDF];

  fifo_ram_1clk #(
    .fifo_data_size (fifo_data_size),
    .fifo_ptr_size  (fifo_ptr_size)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // The RAM prefetches the head that will be current after this edge.
  // When that head is being written this same cycle the RAM still holds
  // the stale word, so the write data is forwarded instead.
  logic                      byp;
  logic [fifo_data_size-1:0] byp_data;

  assign ram_rd_en   = 1'b1;
  assign ram_rd_addr = rd_ptr_nxt[AW-1:0];

  // Forwarding register for a head word written in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else begin
      byp      <= wr_acc && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      byp_data <= wr_data;
    end
  end

  assign rd_data       = byp ? byp_data : ram_q;
  assign rd_data_valid = 1'b0;
`else
  logic rd_vld_q;

  assign ram_rd_en   = rd_acc;
  assign ram_rd_addr = rd_ptr[AW-1:0];

  // One-cycle strobe marking a freshly popped word on rd_data.
  always_ff @(posedge clk) begin
    if (reset) rd_vld_q <= 1'b0;
    else rd_vld_q <= rd_acc;
  end

  assign rd_data       = ram_q;
  assign rd_data_valid = rd_vld_q;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level (depth 16, 8-bit data).
// A queue-based reference model tracks contents, flags and sticky errors.
module tb_sync_fifo_level;

  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [PW:0]   af_level = 5'd14;
  logic [PW:0]   ae_level = 5'd2;
  logic [PW:0]   fifo_count;
  logic          fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic          overflow, underflow;
  logic          clr_err = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_level #(.fifo_data_size(DW), .fifo_ptr_size(PW)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .fifo_count        (fifo_count),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .overflow          (overflow),
    .underflow         (underflow),
    .clr_err           (clr_err)
  );

  int            n_assert = 0;
  int            n_fail   = 0;
  logic [DW-1:0] q[$];
  logic          ovf_m = 1'b0;
  logic          udf_m = 1'b0;
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic r_acc);
    int n;
    n = q.size();
    check("count", 32'(fifo_count), 32'(n));
    check("full", 32'(fifo_full), 32'(n == DEPTH));
    check("empty", 32'(fifo_empty), 32'(n == 0));
    check("almost_full", 32'(fifo_almost_full), 32'(n >= int'(af_level)));
    check("almost_empty", 32'(fifo_almost_empty), 32'(n <= int'(ae_level)));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("underflow", 32'(underflow), 32'(udf_m));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_data_valid", 32'(rd_data_valid), 32'd0);
    if (n != 0) check("head", 32'(rd_data), 32'(q[0]));
`else
    check("rd_data_valid", 32'(rd_data_valid), 32'(r_acc));
    check("rd_data", 32'(rd_data), 32'(last_rd));
`endif
  endtask

  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    logic full_m, empty_m, r_acc, w_acc;
    @(negedge clk);
    wr_valid = wr;
    wr_data  = d;
    rd_valid = rd;
    clr_err  = clr;
    full_m   = (q.size() == DEPTH);
    empty_m  = (q.size() == 0);
    r_acc    = rd && !empty_m;
    w_acc    = wr && (!full_m || r_acc);
    @(posedge clk);
    if (r_acc) last_rd = q.pop_front();
    if (w_acc) q.push_back(d);
    ovf_m = clr ? 1'b0 : (ovf_m | (wr && !w_acc));
    udf_m = clr ? 1'b0 : (udf_m | (rd && empty_m));
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    clr_err  = 1'b0;
    check_all(r_acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    clr_err  = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    ovf_m   = 1'b0;
    udf_m   = 1'b0;
    last_rd = '0;
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_aempty", 32'(fifo_almost_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_afull", 32'(fifo_almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_udf", 32'(underflow), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_data_valid", 32'(rd_data_valid), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    int pw, pr;

    // Fill, overflow, drain in order.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full", 32'(fifo_full), 32'd1);
    check("fill_count", 32'(fifo_count), 32'd16);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(fifo_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_order", 32'(rd_data), 32'(i));
`endif
    end
    check("drain_empty", 32'(fifo_empty), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Threshold crossings, one write per cycle.
    do_reset();
    af_level = 5'd12;
    ae_level = 5'd3;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
      if (k == 3)  check("ae_at3", 32'(fifo_almost_empty), 32'd1);
      if (k == 4)  check("ae_at4", 32'(fifo_almost_empty), 32'd0);
      if (k == 11) check("af_at11", 32'(fifo_almost_full), 32'd0);
      if (k == 12) check("af_at12", 32'(fifo_almost_full), 32'd1);
    end

    // Full with simultaneous push/pop across pointer wrap.
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) step(1'b1, 8'(8'h80 + k), 1'b1, 1'b0);
    check("rw_full_count", 32'(fifo_count), 32'd16);
    check("rw_full_flag", 32'(fifo_full), 32'd1);
    check("rw_full_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 16; k++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow and clear priority.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_set", 32'(underflow), 32'd1);
    check("udf_count", 32'(fifo_count), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("udf_clr_prio", 32'(underflow), 32'd0);

    // Reset mid-burst.
    for (int k = 0; k < 9; k++) step(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'd9);
    do_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("post_rst_head", 32'(rd_data), 32'h3C);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_rst_read", 32'(rd_data), 32'h3C);
`endif

`ifdef SYNC_FIFO_FWFT_EN
    // Fall-through of a single word into an empty FIFO.
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("fwft_not_empty", 32'(fifo_empty), 32'd0);
    check("fwft_head", 32'(rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop_empty", 32'(fifo_empty), 32'd1);
`endif

    // Randomized traffic with varying fill bias and thresholds.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        af_level = 5'($urandom_range(0, 16));
        ae_level = 5'($urandom_range(0, 16));
      end
      case ((i / 100) % 4)
        0:       begin pw = 85; pr = 25; end
        1:       begin pw = 20; pr = 80; end
        2:       begin pw = 60; pr = 60; end
        default: begin pw = 95; pr = 90; end
      endcase
      step(($urandom_range(0, 99) < pw), 8'($urandom), ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
